// File: rtl/vcii_pkg.sv
// Shared types and defaults for the VCII test sequencer.
package vcii_pkg;

    localparam int unsigned BIAS_CYC_DEF  = 16;
    localparam int unsigned DRAIN_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BIAS   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Test configuration: selects which analog switch closes during SETTLE/SAMPLE.
    typedef enum logic [1:0] {
        MODE_SW0 = 2'd0,
        MODE_SW1 = 2'd1,
        MODE_SW2 = 2'd2,
        MODE_SW3 = 2'd3
    } cfg_mode_t;

    function automatic logic [3:0] mode_onehot(input cfg_mode_t mode);
        logic [3:0] oh;
        case (mode)
            MODE_SW0: oh = 4'b0001;
            MODE_SW1: oh = 4'b0010;
            MODE_SW2: oh = 4'b0100;
            MODE_SW3: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vcii_sync2.sv
// Two-flop synchronizer for asynchronous analog-sourced single-bit signals.
module vcii_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vcii_seq_ctrl.sv
// VCII bias/switch/sample sequencer: bias warm-up, settle+sample loop, drain, done.
module vcii_seq_ctrl #(
    parameter int unsigned BIAS_CYC  = vcii_pkg::BIAS_CYC_DEF,
    parameter int unsigned DRAIN_CYC = vcii_pkg::DRAIN_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] settle_cyc,
    input  logic [3:0] n_samples,
    input  logic       cmp_in,
    output logic       bias_en,
    output logic [3:0] sw_en,
    output logic       sample_strobe,
    output logic       busy,
    output logic       done,
    output logic [4:0] ones_count
);

    import vcii_pkg::*;

    localparam logic [7:0] BIAS_LOAD  = 8'(BIAS_CYC - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);

    state_t     state_q,  state_d;
    logic [7:0] cnt_q,    cnt_d;
    logic [4:0] smp_q,    smp_d;
    cfg_mode_t  mode_q,   mode_d;
    logic [7:0] settle_q, settle_d;
    logic [4:0] ones_q,   ones_d;

    logic       bias_en_q, bias_en_d;
    logic [3:0] sw_en_q,   sw_en_d;
    logic       strobe_q,  strobe_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    logic       cmp_sync;
    logic [7:0] settle_load;

    vcii_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_sync)
    );

    // A zero settle request still gets one settle cycle.
    assign settle_load = (settle_q == 8'd0) ? 8'd0 : settle_q - 8'd1;

    // Next-state, shared down-counter, sample counter and ones accumulator.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        smp_d    = smp_q;
        mode_d   = mode_q;
        settle_d = settle_q;
        ones_d   = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    state_d  = ST_BIAS;
                    cnt_d    = BIAS_LOAD;
                    mode_d   = cfg_mode_t'(cfg_mode);
                    settle_d = settle_cyc;
                    smp_d    = (n_samples == 4'd0) ? 5'd16 : {1'b0, n_samples};
                    ones_d   = '0;
                end
            end
            ST_BIAS: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = settle_load;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (cmp_sync && (ones_q != 5'd16)) begin
                    ones_d = ones_q + 5'd1;
                end
                smp_d = smp_q - 5'd1;
                if (smp_q <= 5'd1) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = settle_load;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Disable aborts from any state; the last ones result is kept.
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            smp_d   = '0;
            ones_d  = ones_q;
        end
    end

    // Output decode from the current state; registered so outputs never glitch.
    always_comb begin
        bias_en_d = (state_q == ST_BIAS) || (state_q == ST_SETTLE) ||
                    (state_q == ST_SAMPLE) || (state_q == ST_DRAIN);
        sw_en_d   = ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE)) ?
                    mode_onehot(mode_q) : 4'b0000;
        strobe_d  = (state_q == ST_SAMPLE);
        busy_d    = (state_q != ST_IDLE);
        done_d    = (state_q == ST_DONE);
        if (!ena) begin
            bias_en_d = 1'b0;
            sw_en_d   = '0;
            strobe_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            smp_q     <= '0;
            mode_q    <= MODE_SW0;
            settle_q  <= '0;
            ones_q    <= '0;
            bias_en_q <= 1'b0;
            sw_en_q   <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            mode_q    <= mode_d;
            settle_q  <= settle_d;
            ones_q    <= ones_d;
            bias_en_q <= bias_en_d;
            sw_en_q   <= sw_en_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bias_en       = bias_en_q;
    assign sw_en         = sw_en_q;
    assign sample_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ones_count    = ones_q;

endmodule

// File: tb/tb_vcii_seq_ctrl.sv
// Scoreboard bench for vcii_seq_ctrl: expected output-change events are queued
// per run, and a monitor compares every observed output change against them.
module tb_vcii_seq_ctrl;

    localparam int unsigned B_CYC = 16;
    localparam int unsigned D_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [1:0] cfg_mode;
    logic [7:0] settle_cyc;
    logic [3:0] n_samples;
    logic       cmp_in;
    logic       bias_en;
    logic [3:0] sw_en;
    logic       sample_strobe;
    logic       busy;
    logic       done;
    logic [4:0] ones_count;

    vcii_seq_ctrl #(.BIAS_CYC(B_CYC), .DRAIN_CYC(D_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .start         (start),
        .cfg_mode      (cfg_mode),
        .settle_cyc    (settle_cyc),
        .n_samples     (n_samples),
        .cmp_in        (cmp_in),
        .bias_en       (bias_en),
        .sw_en         (sw_en),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .done          (done),
        .ones_count    (ones_count)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        bias;
        logic [3:0]  sw;
        logic        busy;
        logic        strobe;
        logic        done;
        logic        chk_ones;
        logic [4:0]  ones;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic mon_en = 1'b0;

    logic cmp_lvl = 1'b0;
    logic tog_en  = 1'b0;
    logic cmp_tog = 1'b0;

    function automatic void push_ev(input int unsigned c, input int unsigned cut,
                                    input logic b, input logic [3:0] s, input logic bz,
                                    input logic st, input logic dn,
                                    input logic chk, input logic [4:0] on);
        ev_t e;
        e.cyc = c; e.bias = b; e.sw = s; e.busy = bz; e.strobe = st; e.done = dn;
        e.chk_ones = chk; e.ones = on;
        if (cut == 0 || c < cut) exp_q.push_back(e);
    endfunction

    // Expected output-change events of one run started at edge t0; cut!=0 truncates
    // the run with all outputs dropping to zero at that cycle.
    function automatic void gen_run(input int unsigned t0, input logic [1:0] m,
                                    input logic [7:0] s, input logic [3:0] n,
                                    input int unsigned cut, input logic [4:0] ones);
        int unsigned se, nn, ts;
        logic [3:0] oh;
        se = (s == 8'd0) ? 1 : int'(s);
        nn = (n == 4'd0) ? 16 : int'(n);
        oh = 4'b0001 << m;
        ts = 0;
        push_ev(t0 + 1, cut, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        push_ev(t0 + B_CYC + 1, cut, 1'b1, oh, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int unsigned k = 1; k <= nn; k++) begin
            ts = t0 + B_CYC + k * (se + 1);
            push_ev(ts, cut, 1'b1, oh, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
            push_ev(ts + 1, cut, 1'b1, (k < nn) ? oh : 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        end
        push_ev(ts + 1 + D_CYC, cut, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, ones);
        push_ev(ts + 2 + D_CYC, cut, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        if (cut != 0) push_ev(cut, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, ones);
    endfunction

    // Comparator driver: fixed level, or toggled after every observed strobe.
    initial begin
        cmp_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!tog_en) cmp_tog = cmp_lvl;
            else if (sample_strobe === 1'b1) cmp_tog = !cmp_tog;
            cmp_in = cmp_tog;
        end
    end

    // Monitor: every change of the observed outputs must match the next queued event.
    logic [7:0] obs, prev, exp_v;
    ev_t ev;
    initial begin
        prev = 'x;
        forever begin
            @(negedge clk);
            obs = {bias_en, sw_en, busy, sample_strobe, done};
            if (mon_en && obs !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, obs);
                end else begin
                    ev = exp_q.pop_front();
                    exp_v = {ev.bias, ev.sw, ev.busy, ev.strobe, ev.done};
                    if (cyc != ev.cyc || obs !== exp_v) begin
                        errors++;
                        $display("FAIL out_event got cyc=%0d {bias,sw,busy,stb,done}=%b required cyc=%0d %b",
                                 cyc, obs, ev.cyc, exp_v);
                    end
                    if (ev.chk_ones) begin
                        checks++;
                        if (ones_count !== ev.ones) begin
                            errors++;
                            $display("FAIL ones_count cyc=%0d got=%0d required=%0d", cyc, ones_count, ev.ones);
                        end
                    end
                end
            end
            prev = obs;
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [7:0] s, input logic [3:0] n,
                             output int unsigned t0);
        @(negedge clk);
        cfg_mode = m; settle_cyc = s; n_samples = n; start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    initial begin
        int unsigned t0;
        // reset dominates even with ena and start asserted
        rst_n = 1'b0; ena = 1'b1; start = 1'b1;
        cfg_mode = 2'd0; settle_cyc = 8'd0; n_samples = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_bias_en", {7'd0, bias_en}, 8'd0);
        chk("rst_sw_en",   {4'd0, sw_en},   8'd0);
        chk("rst_strobe",  {7'd0, sample_strobe}, 8'd0);
        chk("rst_busy",    {7'd0, busy},    8'd0);
        chk("rst_done",    {7'd0, done},    8'd0);
        chk("rst_ones",    {3'd0, ones_count}, 8'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // defaults: mode 2, settle 10, two samples, comparator high
        cmp_lvl = 1'b1;
        repeat (4) @(negedge clk);
        start_run(2'd2, 8'd10, 4'd2, t0);
        gen_run(t0, 2'd2, 8'd10, 4'd2, 0, 5'd2);
        wait_idle("basic");
        chk("ones_hold", {3'd0, ones_count}, 8'd2);

        // 16 samples, minimum settle, comparator low
        cmp_lvl = 1'b0;
        repeat (4) @(negedge clk);
        start_run(2'd1, 8'd0, 4'd0, t0);
        gen_run(t0, 2'd1, 8'd0, 4'd0, 0, 5'd0);
        wait_idle("sixteen");

        // comparator toggled after each sample: 1,0,1,0
        cmp_lvl = 1'b1;
        repeat (4) @(negedge clk);
        tog_en = 1'b1;
        start_run(2'd3, 8'd10, 4'd4, t0);
        gen_run(t0, 2'd3, 8'd10, 4'd4, 0, 5'd2);
        wait_idle("toggle");
        tog_en = 1'b0;
        repeat (4) @(negedge clk);

        // ena dropped during cycle 20
        start_run(2'd2, 8'd10, 4'd2, t0);
        gen_run(t0, 2'd2, 8'd10, 4'd2, t0 + 21, 5'd0);
        wait_cyc(t0 + 20);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        wait_idle("ena_abort");

        // reset during cycle 30, then an identical restart
        start_run(2'd2, 8'd10, 4'd2, t0);
        gen_run(t0, 2'd2, 8'd10, 4'd2, t0 + 31, 5'd0);
        wait_cyc(t0 + 30);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("reset_abort");
        start_run(2'd2, 8'd10, 4'd2, t0);
        gen_run(t0, 2'd2, 8'd10, 4'd2, 0, 5'd2);
        wait_idle("restart");

        // start re-asserted and inputs changed mid-run
        start_run(2'd0, 8'd3, 4'd3, t0);
        gen_run(t0, 2'd0, 8'd3, 4'd3, 0, 5'd3);
        wait_cyc(t0 + 10);
        start = 1'b1; cfg_mode = 2'd3; settle_cyc = 8'd0; n_samples = 4'd1;
        wait_cyc(t0 + 25);
        start = 1'b0;
        wait_idle("busy_start");

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vcii_seq_ctrl.md
VCII_SEQ_CTRL -- requirements
Module: vcii_seq_ctrl

Interface
REQ-001 Parameter BIAS_CYC, default 16: bias warm-up length in clock cycles (range 1..255).
REQ-002 Parameter DRAIN_CYC, default 2: break-before-make drain length in cycles (range 1..15).
REQ-003 Port clk, input, 1: single system clock. The block SHALL use only this clock.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port ena, input, 1: design enable. Low aborts any run.
REQ-006 Port start, input, 1: run request, level-sampled in IDLE.
REQ-007 Port cfg_mode, input, 2: VCII test configuration select.
REQ-008 Port settle_cyc, input, 8: settle cycles before each sample.
REQ-009 Port n_samples, input, 4: samples per run; 0 means 16.
REQ-010 Port cmp_in, input, 1: asynchronous comparator output from the analog macro.
REQ-011 Port bias_en, output, 1: VCII bias enable.
REQ-012 Port sw_en, output, 4: one-hot analog switch enables.
REQ-013 Port sample_strobe, output, 1: one-cycle sample pulse for external observation.
REQ-014 Port busy, output, 1: run in progress.
REQ-015 Port done, output, 1: one-cycle run-complete pulse.
REQ-016 Port ones_count, output, 5: number of samples with comparator high in the last completed run.

Function
REQ-017 FSM states: IDLE, BIAS, SETTLE, SAMPLE, DRAIN, DONE.
REQ-018 IDLE: when start=1 and ena=1 at a clock edge, the block SHALL latch cfg_mode, settle_cyc and n_samples, clear ones_count, and go to BIAS.
REQ-019 BIAS: bias_en=1, sw_en=0; SHALL last exactly BIAS_CYC cycles, then go to SETTLE.
REQ-020 SETTLE: bias_en=1, sw_en=onehot(latched cfg_mode) (mode 0 -> 4'b0001 ... mode 3 -> 4'b1000); SHALL last max(settle_cyc,1) cycles, then go to SAMPLE.
REQ-021 SAMPLE: one cycle with sample_strobe=1; ones_count SHALL increment when synchronized cmp is 1; then go to SETTLE if samples remain, otherwise to DRAIN.
REQ-022 DRAIN: sw_en=0, bias_en=1, for DRAIN_CYC cycles, then go to DONE.
REQ-023 DONE: one cycle with done=1, bias_en=0, sw_en=0; then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy SHALL be ignored; no queuing.
REQ-026 Input changes during a run SHALL have no effect; only latched values are used.
REQ-027 cmp_in SHALL pass through a 2-flop synchronizer; SAMPLE uses the synchronizer output.
REQ-028 ones_count SHALL saturate at 16, hold its value after DONE, and clear only on a new start or on reset.
REQ-029 sw_en and bias_en SHALL be registered outputs with no glitches. sw_en SHALL never be nonzero while bias_en=0.
REQ-030 If ena=0 at any edge in a non-IDLE state, the FSM SHALL go to IDLE with all outputs 0 except ones_count, which holds. done SHALL not pulse.
REQ-031 Timing, with start sampled at edge 0: first sample_strobe SHALL occur at cycle BIAS_CYC+max(settle_cyc,1)+1. Each further sample SHALL follow max(settle_cyc,1)+1 cycles later.

Reset
REQ-032 When rst_n=0 at an edge: state=IDLE, all outputs 0, ones_count=0, synchronizer flops=0, counters=0.
REQ-033 Reset during a run SHALL take effect at that edge, with the same result as REQ-032.

Structure
REQ-034 Package vcii_pkg SHALL hold the state enum, the cfg_mode encoding and the onehot decode function, and the BIAS_CYC/DRAIN_CYC defaults.
REQ-035 The synchronizer SHALL be the sub-module vcii_sync2, which is reusable for other analog-sourced signals.
REQ-036 One down-counter (8-bit) SHALL be shared by the BIAS, SETTLE and DRAIN states. A separate 5-bit sample counter SHALL be used.

Verification
REQ-037 Defaults, settle_cyc=10, n_samples=2, cfg_mode=2, cmp_in=1, start at edge 0 -> bias_en cycles 1-40; sw_en=4'b0100 cycles 17-38; strobes at cycles 27 and 38; done at cycle 41; ones_count=2.
REQ-038 n_samples=0, settle_cyc=0, cmp_in=0 -> 16 strobes spaced 2 cycles apart; ones_count=0; done once.
REQ-039 cmp_in toggling every SAMPLE, n_samples=4 -> ones_count=2, accounting for the 2-cycle synchronizer delay.
REQ-040 ena dropped at cycle 20 of the REQ-037 run -> at cycle 21 bias_en=0, sw_en=0, busy=0; no done pulse.
REQ-041 rst_n=0 at cycle 30 of the REQ-037 run -> all outputs 0 at cycle 31. A restart then reproduces the REQ-037 timing.
REQ-042 start re-asserted while busy, and cfg_mode changed mid-run -> no restart, sw_en unchanged, and a single done pulse.
